hunt_round_ctl: RTL and testbench

//  Parametrised round/ammo/score controller for N simultaneous targets. Replaces the single-duck

---
 rtl/hunt_round_ctl_pkg.sv | 28 ++
 rtl/hunt_round_ctl_hit_box_detect.sv | 25 ++
 rtl/hunt_round_ctl.sv | 247 ++++++++++++++++++++++++
 tb/tb_hunt_round_ctl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hunt_round_ctl_pkg.sv
// Shared types, widths and saturating arithmetic for the duck-hunt round controller.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ROUND_INTRO,
    HUNT,
    ROUND_END,
    GAME_OVER
  } hunt_state_t;

  localparam int SCORE_W = 7;
  localparam int AMMO_W  = 7;
  localparam int MAG_W   = 3;
  localparam int ROUND_W = 4;
  localparam int POS_W   = 12;

  // Adds b to a, clamping at max so the two-digit display never wraps.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W-1:0] b,
                                                 input logic [SCORE_W-1:0] max);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max}) return max;
    return sum[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/hunt_round_ctl_hit_box_detect.sv
// Combinational test of whether the cursor lies inside one target's hit box.
module hit_box_detect
  import game_pkg::*;
#(
  parameter int TARGET_W = 64,
  parameter int TARGET_H = 64
) (
  input  logic [POS_W-1:0] i_mouse_x,
  input  logic [POS_W-1:0] i_mouse_y,
  input  logic [POS_W-1:0] i_target_x,
  input  logic [POS_W-1:0] i_target_y,
  output logic             o_inside
);

  // One extra bit so a target near the screen edge cannot wrap its far corner.
  logic [POS_W:0] w_x_end;
  logic [POS_W:0] w_y_end;

  assign w_x_end = {1'b0, i_target_x} + (POS_W+1)'(TARGET_W);
  assign w_y_end = {1'b0, i_target_y} + (POS_W+1)'(TARGET_H);

  assign o_inside = (i_mouse_x >= i_target_x) && ({1'b0, i_mouse_x} < w_x_end) &&
                    (i_mouse_y >= i_target_y) && ({1'b0, i_mouse_y} < w_y_end);

endmodule

// File: rtl/hunt_round_ctl.sv
// Round / ammo / score controller for NUM_TARGETS simultaneous targets.
// Handshake: none; fire/reload act on level-to-high edges and every effect appears one clock later.
module hunt_round_ctl
  import game_pkg::*;
#(
  parameter int NUM_TARGETS  = 2,
  parameter int MAG_SIZE     = 3,
  parameter int TOTAL_AMMO   = 30,
  parameter int ROUNDS       = 10,
  parameter int TARGET_W     = 64,
  parameter int TARGET_H     = 64,
  parameter int INTRO_CYCLES = 65000000,
  parameter int DOG_CYCLES   = 97500000,
  parameter int SCORE_MAX    = 99
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         game_enable,
  input  logic                         left_mouse,
  input  logic                         right_mouse,
  input  logic [POS_W-1:0]             mouse_xpos,
  input  logic [POS_W-1:0]             mouse_ypos,
  input  logic [NUM_TARGETS*POS_W-1:0] target_xpos,
  input  logic [NUM_TARGETS*POS_W-1:0] target_ypos,
  input  logic [NUM_TARGETS-1:0]       target_escaped,
  output logic [NUM_TARGETS-1:0]       target_killed,
  output logic                         hunt_start,
  output logic                         dog_bird_enable,
  output logic [MAG_W-1:0]             bullets_in_magazine,
  output logic [AMMO_W-1:0]            bullets_left,
  output logic                         show_reload_char,
  output logic [SCORE_W-1:0]           my_score,
  output logic [SCORE_W-1:0]           enemy_score,
  output logic [ROUND_W-1:0]           round_num,
  output logic                         game_finished,
  output hunt_state_t                  o_dbg_state
);

  localparam int TMR_MAX = (INTRO_CYCLES > DOG_CYCLES) ? INTRO_CYCLES : DOG_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  // Timer holds "cycles remaining minus one" so the phase lasts exactly the configured count.
  localparam logic [TMR_W-1:0]   INTRO_LOAD = TMR_W'(INTRO_CYCLES - 1);
  localparam logic [TMR_W-1:0]   DOG_LOAD   = TMR_W'(DOG_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SMAX       = SCORE_W'(SCORE_MAX);

  hunt_state_t                r_state, w_state_nxt;
  logic [TMR_W-1:0]           r_timer, w_timer_nxt;
  logic [MAG_W-1:0]           r_mag, w_mag_nxt;
  logic [AMMO_W-1:0]          r_bullets, w_bullets_nxt;
  logic [SCORE_W-1:0]         r_my_score, w_my_nxt;
  logic [SCORE_W-1:0]         r_enemy_score, w_enemy_nxt;
  logic [ROUND_W-1:0]         r_round, w_round_nxt;
  logic [NUM_TARGETS-1:0]     r_killed, w_killed_nxt;
  logic [NUM_TARGETS-1:0]     r_resolved, w_resolved_nxt;
  logic                       r_left_prev;
  logic                       r_right_prev;

  logic [NUM_TARGETS-1:0]     w_inside;
  logic [NUM_TARGETS-1:0]     w_hit;
  logic                       w_found;
  logic                       w_fire;
  logic                       w_reload;
  logic                       w_shot;
  logic                       w_empty;
  logic [NUM_TARGETS-1:0]     w_kill;
  logic [NUM_TARGETS-1:0]     w_esc;
  logic [AMMO_W-1:0]          w_space;
  logic [AMMO_W-1:0]          w_reload_amt;
  logic [MAG_W-1:0]           w_mag_rld;
  logic [AMMO_W-1:0]          w_bullets_rld;

  function automatic logic [SCORE_W-1:0] count_ones(input logic [NUM_TARGETS-1:0] v);
    logic [SCORE_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_TARGETS; i++) n = n + SCORE_W'(v[i]);
    return n;
  endfunction

  for (genvar g = 0; g < NUM_TARGETS; g++) begin : g_hit
    hit_box_detect #(
      .TARGET_W(TARGET_W),
      .TARGET_H(TARGET_H)
    ) u_hit (
      .i_mouse_x (mouse_xpos),
      .i_mouse_y (mouse_ypos),
      .i_target_x(target_xpos[g*POS_W +: POS_W]),
      .i_target_y(target_ypos[g*POS_W +: POS_W]),
      .o_inside  (w_inside[g])
    );
  end

  // A simultaneous fire edge always swallows the reload edge.
  assign w_fire   = left_mouse & ~r_left_prev;
  assign w_reload = right_mouse & ~r_right_prev & ~w_fire;
  assign w_shot   = (r_state == HUNT) && w_fire && (r_mag != '0);
  assign w_empty  = (r_mag == '0) && (r_bullets == '0);

  // Lowest-index unresolved target under the cursor takes the shot.
  always_comb begin
    w_hit   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (!w_found && w_inside[i] && !r_resolved[i]) begin
        w_hit[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
  end

  assign w_kill = w_shot ? w_hit : '0;
  assign w_esc  = target_escaped & ~r_resolved & ~w_kill;

  assign w_space       = AMMO_W'(MAG_W'(MAG_SIZE) - r_mag);
  assign w_reload_amt  = (w_space < r_bullets) ? w_space : r_bullets;
  assign w_mag_rld     = w_reload ? r_mag + w_reload_amt[MAG_W-1:0] : r_mag;
  assign w_bullets_rld = w_reload ? r_bullets - w_reload_amt : r_bullets;

  always_comb begin
    w_state_nxt    = r_state;
    w_timer_nxt    = r_timer;
    w_mag_nxt      = r_mag;
    w_bullets_nxt  = r_bullets;
    w_my_nxt       = r_my_score;
    w_enemy_nxt    = r_enemy_score;
    w_round_nxt    = r_round;
    w_killed_nxt   = r_killed;
    w_resolved_nxt = r_resolved;

    case (r_state)
      IDLE: begin
        if (game_enable) begin
          w_state_nxt    = ROUND_INTRO;
          w_timer_nxt    = INTRO_LOAD;
          w_mag_nxt      = MAG_W'(MAG_SIZE);
          w_bullets_nxt  = AMMO_W'(TOTAL_AMMO - MAG_SIZE);
          w_my_nxt       = '0;
          w_enemy_nxt    = '0;
          w_round_nxt    = ROUND_W'(1);
          w_killed_nxt   = '0;
          w_resolved_nxt = '0;
        end
      end

      ROUND_INTRO: begin
        w_mag_nxt     = w_mag_rld;
        w_bullets_nxt = w_bullets_rld;
        if (r_timer == '0) w_state_nxt = HUNT;
        else               w_timer_nxt = r_timer - TMR_W'(1);
      end

      HUNT: begin
        if (w_empty) begin
          // Out of ammo: every target still flying counts as an escape.
          w_enemy_nxt    = sat_add(r_enemy_score, count_ones(~r_resolved), SMAX);
          w_resolved_nxt = '1;
          w_state_nxt    = ROUND_END;
          w_timer_nxt    = DOG_LOAD;
        end else begin
          w_mag_nxt      = w_shot ? r_mag - MAG_W'(1) : w_mag_rld;
          w_bullets_nxt  = w_bullets_rld;
          w_killed_nxt   = r_killed | w_kill;
          w_resolved_nxt = r_resolved | w_kill | w_esc;
          w_my_nxt       = sat_add(r_my_score, SCORE_W'(|w_kill), SMAX);
          w_enemy_nxt    = sat_add(r_enemy_score, count_ones(w_esc), SMAX);
          if (&w_resolved_nxt) begin
            w_state_nxt = ROUND_END;
            w_timer_nxt = DOG_LOAD;
          end
        end
      end

      ROUND_END: begin
        w_mag_nxt     = w_mag_rld;
        w_bullets_nxt = w_bullets_rld;
        if (r_timer != '0) begin
          w_timer_nxt = r_timer - TMR_W'(1);
        end else if ((r_round == ROUND_W'(ROUNDS)) || w_empty) begin
          w_state_nxt = GAME_OVER;
        end else begin
          w_state_nxt    = ROUND_INTRO;
          w_timer_nxt    = INTRO_LOAD;
          w_round_nxt    = r_round + ROUND_W'(1);
          w_killed_nxt   = '0;
          w_resolved_nxt = '0;
        end
      end

      GAME_OVER: ;

      default: w_state_nxt = IDLE;
    endcase

    if (!game_enable) begin
      w_state_nxt    = IDLE;
      w_timer_nxt    = '0;
      w_mag_nxt      = '0;
      w_bullets_nxt  = '0;
      w_my_nxt       = '0;
      w_enemy_nxt    = '0;
      w_round_nxt    = '0;
      w_killed_nxt   = '0;
      w_resolved_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_timer       <= '0;
      r_mag         <= '0;
      r_bullets     <= '0;
      r_my_score    <= '0;
      r_enemy_score <= '0;
      r_round       <= '0;
      r_killed      <= '0;
      r_resolved    <= '0;
      r_left_prev   <= 1'b0;
      r_right_prev  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_timer       <= w_timer_nxt;
      r_mag         <= w_mag_nxt;
      r_bullets     <= w_bullets_nxt;
      r_my_score    <= w_my_nxt;
      r_enemy_score <= w_enemy_nxt;
      r_round       <= w_round_nxt;
      r_killed      <= w_killed_nxt;
      r_resolved    <= w_resolved_nxt;
      r_left_prev   <= left_mouse;
      r_right_prev  <= right_mouse;
    end
  end

  assign target_killed       = r_killed;
  assign hunt_start          = (r_state == HUNT);
  assign dog_bird_enable     = (r_state == ROUND_END) && (|r_killed);
  assign bullets_in_magazine = r_mag;
  assign bullets_left        = r_bullets;
  assign show_reload_char    = (r_mag == '0) && (r_bullets != '0);
  assign my_score            = r_my_score;
  assign enemy_score         = r_enemy_score;
  assign round_num           = r_round;
  assign game_finished       = (r_state == GAME_OVER);
  assign o_dbg_state         = r_state;

endmodule

// File: tb/tb_hunt_round_ctl.sv
// Bench for hunt_round_ctl: directed vector table, hand-built corner games, then random play vs a model.
module tb_hunt_round_ctl;
  import game_pkg::*;

  localparam int NT    = 2;
  localparam int MAG   = 3;
  localparam int TOT   = 6;
  localparam int RND   = 2;
  localparam int TW    = 64;
  localparam int TH    = 64;
  localparam int INTRO = 4;
  localparam int DOG   = 4;
  localparam int SMAX  = 99;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst;
  logic en, lm, rm;
  logic [11:0] mouse_x, mouse_y;
  logic [NT*12-1:0] tgt_x, tgt_y;
  logic [NT-1:0] esc;

  logic [NT-1:0] target_killed;
  logic hunt_start, dog_bird_enable, show_reload_char, game_finished;
  logic [2:0] bullets_in_magazine;
  logic [6:0] bullets_left, my_score, enemy_score;
  logic [3:0] round_num;
  hunt_state_t dbg_state;

  always #5 clk = ~clk;

  hunt_round_ctl #(
    .NUM_TARGETS(NT), .MAG_SIZE(MAG), .TOTAL_AMMO(TOT), .ROUNDS(RND),
    .TARGET_W(TW), .TARGET_H(TH), .INTRO_CYCLES(INTRO), .DOG_CYCLES(DOG), .SCORE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst), .game_enable(en), .left_mouse(lm), .right_mouse(rm),
    .mouse_xpos(mouse_x), .mouse_ypos(mouse_y), .target_xpos(tgt_x), .target_ypos(tgt_y),
    .target_escaped(esc), .target_killed(target_killed), .hunt_start(hunt_start),
    .dog_bird_enable(dog_bird_enable), .bullets_in_magazine(bullets_in_magazine),
    .bullets_left(bullets_left), .show_reload_char(show_reload_char), .my_score(my_score),
    .enemy_score(enemy_score), .round_num(round_num), .game_finished(game_finished),
    .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model (game rules, plain integers) ----------------
  // phase: 0 idle, 1 intro, 2 hunt, 3 round end, 4 game over
  int m_phase, m_wait, m_mag, m_bul, m_my, m_en, m_round;
  bit m_kill[NT];
  bit m_res[NT];
  bit m_pl, m_pr;

  function automatic int sat(input int x);
    return (x > SMAX) ? SMAX : x;
  endfunction

  task automatic model_clear();
    m_phase = 0; m_wait = 0; m_mag = 0; m_bul = 0; m_my = 0; m_en = 0; m_round = 0;
    for (int i = 0; i < NT; i++) begin m_kill[i] = 0; m_res[i] = 0; end
  endtask

  task automatic model_reload(input bit rel);
    int amt;
    if (rel) begin
      amt = MAG - m_mag;
      if (m_bul < amt) amt = m_bul;
      m_mag += amt;
      m_bul -= amt;
    end
  endtask

  function automatic bit m_inside(input int i);
    int tx, ty;
    tx = int'(tgt_x[i*12 +: 12]);
    ty = int'(tgt_y[i*12 +: 12]);
    return (int'(mouse_x) >= tx) && (int'(mouse_x) < tx + TW) &&
           (int'(mouse_y) >= ty) && (int'(mouse_y) < ty + TH);
  endfunction

  task automatic model_step();
    bit fire, rel, all_res;
    int hit, cnt;
    fire = lm && !m_pl;
    rel  = rm && !m_pr && !fire;
    m_pl = lm;
    m_pr = rm;
    if (!en) begin
      model_clear();
      return;
    end
    case (m_phase)
      0: begin
        model_clear();
        m_phase = 1; m_wait = INTRO; m_mag = MAG; m_bul = TOT - MAG; m_round = 1;
      end
      1: begin
        model_reload(rel);
        m_wait--;
        if (m_wait == 0) m_phase = 2;
      end
      2: begin
        if (m_mag == 0 && m_bul == 0) begin
          cnt = 0;
          for (int i = 0; i < NT; i++) if (!m_res[i]) begin cnt++; m_res[i] = 1; end
          m_en = sat(m_en + cnt);
          m_phase = 3; m_wait = DOG;
        end else begin
          hit = -1;
          if (fire && m_mag > 0) begin
            m_mag--;
            for (int i = 0; i < NT; i++) if (hit < 0 && !m_res[i] && m_inside(i)) hit = i;
          end
          cnt = 0;
          for (int i = 0; i < NT; i++) if (esc[i] && !m_res[i] && i != hit) cnt++;
          for (int i = 0; i < NT; i++) if (esc[i]) m_res[i] = 1;
          if (hit >= 0) begin
            m_kill[hit] = 1; m_res[hit] = 1; m_my = sat(m_my + 1);
          end
          m_en = sat(m_en + cnt);
          model_reload(rel);
          all_res = 1;
          for (int i = 0; i < NT; i++) if (!m_res[i]) all_res = 0;
          if (all_res) begin m_phase = 3; m_wait = DOG; end
        end
      end
      3: begin
        model_reload(rel);
        m_wait--;
        if (m_wait == 0) begin
          if (m_round == RND || (m_mag == 0 && m_bul == 0)) begin
            m_phase = 4;
          end else begin
            m_phase = 1; m_wait = INTRO; m_round++;
            for (int i = 0; i < NT; i++) begin m_kill[i] = 0; m_res[i] = 0; end
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".round"}, round_num, m_round);
    chk({tag, ".mag"}, bullets_in_magazine, m_mag);
    chk({tag, ".bullets"}, bullets_left, m_bul);
    chk({tag, ".my"}, my_score, m_my);
    chk({tag, ".enemy"}, enemy_score, m_en);
    chk({tag, ".killed"}, target_killed, {m_kill[1], m_kill[0]});
    chk({tag, ".hunt"}, hunt_start, m_phase == 2);
    chk({tag, ".dog"}, dog_bird_enable, (m_phase == 3) && (m_kill[0] || m_kill[1]));
    chk({tag, ".over"}, game_finished, m_phase == 4);
    chk({tag, ".reload_char"}, show_reload_char, (m_mag == 0) && (m_bul != 0));
  endtask

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    if (rst) begin
      model_clear(); m_pl = 0; m_pr = 0;
    end else begin
      model_step();
    end
    #1;
  endtask

  task automatic set_layout(input int tp);
    if (tp == 0) begin tgt_x = {12'd400, 12'd100}; tgt_y = {12'd300, 12'd100}; end
    else         begin tgt_x = {12'd100, 12'd100}; tgt_y = {12'd100, 12'd100}; end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic en, lm, rm;
    int mx, my, tp;
    logic [1:0] esc;
    int hold;
    int e_round, e_mag, e_bul, e_my, e_en;
    logic [1:0] e_kill;
    logic e_hunt, e_dog, e_over, e_rel;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input int en_i, lm_i, rm_i, mx_i, my_i, tp_i, esc_i, hold_i,
                             rnd, mag, bul, mys, ens, kill, hunt, dog, over, rel);
    vec_t r;
    r.en = en_i[0]; r.lm = lm_i[0]; r.rm = rm_i[0];
    r.mx = mx_i; r.my = my_i; r.tp = tp_i; r.esc = esc_i[1:0]; r.hold = hold_i;
    r.e_round = rnd; r.e_mag = mag; r.e_bul = bul; r.e_my = mys; r.e_en = ens;
    r.e_kill = kill[1:0]; r.e_hunt = hunt[0]; r.e_dog = dog[0]; r.e_over = over[0]; r.e_rel = rel[0];
    return r;
  endfunction

  task automatic check_vec(input vec_t r, input int k);
    string t;
    t = $sformatf("vec%0d", k);
    chk({t, ".round"}, round_num, r.e_round);
    chk({t, ".mag"}, bullets_in_magazine, r.e_mag);
    chk({t, ".bullets"}, bullets_left, r.e_bul);
    chk({t, ".my"}, my_score, r.e_my);
    chk({t, ".enemy"}, enemy_score, r.e_en);
    chk({t, ".killed"}, target_killed, r.e_kill);
    chk({t, ".hunt"}, hunt_start, r.e_hunt);
    chk({t, ".dog"}, dog_bird_enable, r.e_dog);
    chk({t, ".over"}, game_finished, r.e_over);
    chk({t, ".reload_char"}, show_reload_char, r.e_rel);
  endtask

  initial begin
    int k0, cyc;
    rst = 1'b1; en = 0; lm = 0; rm = 0; mouse_x = '0; mouse_y = '0; esc = '0;
    set_layout(0);
    step(); step();
    rst = 1'b0;
    step();
    chk("reset.round", round_num, 0);
    chk("reset.mag", bullets_in_magazine, 0);
    chk("reset.bullets", bullets_left, 0);
    chk("reset.killed", target_killed, 0);
    chk("reset.hunt", hunt_start, 0);
    chk("reset.over", game_finished, 0);

    // Game 1: intro timing, single kill, escape of a resolved target, round 2,
    // overlapping targets, fire+reload collision, reload, ammo exhaustion, disable.
    //            en lm rm  mx  my tp esc hold  rnd mag bul my en kill hunt dog over rel
    vecs.push_back(v(1, 0, 0,   0,   0, 0, 0, 1,  1, 3, 3, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 0, 0,   0,   0, 0, 0, 3,  1, 3, 3, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 0, 0,   0,   0, 0, 0, 1,  1, 3, 3, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(v(1, 1, 0, 120, 130, 0, 0, 1,  1, 2, 3, 1, 0, 1, 1, 0, 0, 0));
    vecs.push_back(v(1, 0, 0, 120, 130, 0, 0, 1,  1, 2, 3, 1, 0, 1, 1, 0, 0, 0));
    vecs.push_back(v(1, 0, 0, 120, 130, 0, 3, 1,  1, 2, 3, 1, 1, 1, 0, 1, 0, 0));
    vecs.push_back(v(1, 0, 0,   0,   0, 0, 0, 3,  1, 2, 3, 1, 1, 1, 0, 1, 0, 0));
    vecs.push_back(v(1, 0, 0,   0,   0, 1, 0, 1,  2, 2, 3, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 0, 0,   0,   0, 1, 0, 3,  2, 2, 3, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 0, 0,   0,   0, 1, 0, 1,  2, 2, 3, 1, 1, 0, 1, 0, 0, 0));
    vecs.push_back(v(1, 1, 0, 120, 130, 1, 0, 1,  2, 1, 3, 2, 1, 1, 1, 0, 0, 0));
    vecs.push_back(v(1, 0, 0, 120, 130, 1, 0, 1,  2, 1, 3, 2, 1, 1, 1, 0, 0, 0));
    vecs.push_back(v(1, 1, 0,   0,   0, 1, 0, 1,  2, 0, 3, 2, 1, 1, 1, 0, 0, 1));
    vecs.push_back(v(1, 0, 0,   0,   0, 1, 0, 1,  2, 0, 3, 2, 1, 1, 1, 0, 0, 1));
    vecs.push_back(v(1, 1, 1,   0,   0, 1, 0, 1,  2, 0, 3, 2, 1, 1, 1, 0, 0, 1));
    vecs.push_back(v(1, 0, 0,   0,   0, 1, 0, 1,  2, 0, 3, 2, 1, 1, 1, 0, 0, 1));
    vecs.push_back(v(1, 0, 1,   0,   0, 1, 0, 1,  2, 3, 0, 2, 1, 1, 1, 0, 0, 0));
    vecs.push_back(v(1, 0, 0,   0,   0, 1, 0, 1,  2, 3, 0, 2, 1, 1, 1, 0, 0, 0));
    vecs.push_back(v(1, 1, 0,   0,   0, 1, 0, 1,  2, 2, 0, 2, 1, 1, 1, 0, 0, 0));
    vecs.push_back(v(1, 0, 0,   0,   0, 1, 0, 1,  2, 2, 0, 2, 1, 1, 1, 0, 0, 0));
    vecs.push_back(v(1, 1, 0,   0,   0, 1, 0, 1,  2, 1, 0, 2, 1, 1, 1, 0, 0, 0));
    vecs.push_back(v(1, 0, 0,   0,   0, 1, 0, 1,  2, 1, 0, 2, 1, 1, 1, 0, 0, 0));
    vecs.push_back(v(1, 1, 0,   0,   0, 1, 0, 1,  2, 0, 0, 2, 1, 1, 1, 0, 0, 0));
    vecs.push_back(v(1, 0, 0,   0,   0, 1, 0, 1,  2, 0, 0, 2, 2, 1, 0, 1, 0, 0));
    vecs.push_back(v(1, 0, 0,   0,   0, 1, 0, 3,  2, 0, 0, 2, 2, 1, 0, 1, 0, 0));
    vecs.push_back(v(1, 0, 0,   0,   0, 1, 0, 1,  2, 0, 0, 2, 2, 1, 0, 0, 1, 0));
    vecs.push_back(v(1, 0, 0,   0,   0, 1, 0, 2,  2, 0, 0, 2, 2, 1, 0, 0, 1, 0));
    vecs.push_back(v(0, 0, 0,   0,   0, 1, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Game 2: both targets escape in one cycle, no kills -> dog stays off.
    vecs.push_back(v(1, 0, 0,   0,   0, 0, 0, 1,  1, 3, 3, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 0, 0,   0,   0, 0, 0, 4,  1, 3, 3, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(v(1, 0, 0,   0,   0, 0, 3, 1,  1, 3, 3, 0, 2, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0,   0,   0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Game 3: hit and escape on the same target, hit-box edges inclusive/exclusive.
    vecs.push_back(v(1, 0, 0,   0,   0, 0, 0, 1,  1, 3, 3, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 0, 0,   0,   0, 0, 0, 4,  1, 3, 3, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(v(1, 1, 0, 163, 163, 0, 1, 1,  1, 2, 3, 1, 0, 1, 1, 0, 0, 0));
    vecs.push_back(v(1, 0, 0, 164, 100, 0, 0, 1,  1, 2, 3, 1, 0, 1, 1, 0, 0, 0));
    vecs.push_back(v(1, 1, 0, 464, 300, 0, 0, 1,  1, 1, 3, 1, 0, 1, 1, 0, 0, 0));
    vecs.push_back(v(1, 0, 0, 464, 300, 0, 0, 1,  1, 1, 3, 1, 0, 1, 1, 0, 0, 0));
    vecs.push_back(v(1, 1, 0, 463, 363, 0, 0, 1,  1, 0, 3, 2, 0, 3, 0, 1, 0, 1));
    vecs.push_back(v(0, 0, 0,   0,   0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    for (int k = 0; k < vecs.size(); k++) begin
      en = vecs[k].en; lm = vecs[k].lm; rm = vecs[k].rm;
      mouse_x = 12'(vecs[k].mx); mouse_y = 12'(vecs[k].my);
      set_layout(vecs[k].tp);
      esc = vecs[k].esc;
      for (int h = 0; h < vecs[k].hold; h++) step();
      check_vec(vecs[k], k);
    end

    // Randomised play against the model from a fresh reset.
    rst = 1'b1; en = 0; lm = 0; rm = 0; esc = '0;
    step();
    rst = 1'b0;
    step();
    check_model("rand.start");
    cyc = 0;
    while (cyc < 4000) begin
      if (cyc % 40 == 0) begin
        tgt_x = {12'($urandom_range(10, 600)), 12'($urandom_range(10, 600))};
        tgt_y = {12'($urandom_range(10, 400)), 12'($urandom_range(10, 400))};
      end
      if (m_phase == 4 || m_phase == 0) en = ($urandom_range(0, 9) < 3) ? 1'b0 : 1'b1;
      else                               en = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      lm = ($urandom_range(0, 3) == 0);
      rm = ($urandom_range(0, 5) == 0);
      k0 = $urandom_range(0, NT - 1);
      mouse_x = 12'(int'(tgt_x[k0*12 +: 12]) + $urandom_range(0, 69) - 3);
      mouse_y = 12'(int'(tgt_y[k0*12 +: 12]) + $urandom_range(0, 69) - 3);
      for (int i = 0; i < NT; i++) esc[i] = ($urandom_range(0, 24) == 0);
      step();
      check_model($sformatf("rand%0d", cyc));
      cyc++;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
